// File: rtl/sine_tone_analyzer.sv
// Tone checker: detects hysteresis-qualified rising zero crossings on a strobed
// sample stream, measures period and per-cycle peaks, and declares lock.
module sine_tone_analyzer #(
  parameter int unsigned SAMPLE_WIDTH     = 16,
  parameter int unsigned PERIOD_WIDTH     = 8,
  parameter int unsigned EXPECTED_PERIOD  = 48,
  parameter int unsigned PERIOD_TOLERANCE = 1,
  parameter int unsigned LOCK_COUNT       = 4,
  parameter int unsigned HYSTERESIS       = 256
) (
  input  logic                    audioClock,
  input  logic                    resetN,
  input  logic                    sampleEnable,
  input  logic [SAMPLE_WIDTH-1:0] sample,
  output logic                    measValid,
  output logic [PERIOD_WIDTH-1:0] period,
  output logic [SAMPLE_WIDTH-1:0] peakPos,
  output logic [SAMPLE_WIDTH-1:0] peakNeg,
  output logic                    locked,
  output logic                    timeout,
  output logic [15:0]             errCount
);

  localparam int unsigned PW1    = PERIOD_WIDTH + 1;
  localparam int unsigned GW     = $clog2(LOCK_COUNT + 1);
  localparam int unsigned PER_LO = (EXPECTED_PERIOD > PERIOD_TOLERANCE) ?
                                   EXPECTED_PERIOD - PERIOD_TOLERANCE : 0;
  localparam int unsigned PER_HI = EXPECTED_PERIOD + PERIOD_TOLERANCE;
  localparam logic [PERIOD_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_COUNT);
  localparam logic signed [SAMPLE_WIDTH-1:0] ARM_LEVEL =
    SAMPLE_WIDTH'(-$signed(HYSTERESIS));

  logic                           armed;
  logic                           primed;
  logic [PERIOD_WIDTH-1:0]        cnt;
  logic signed [SAMPLE_WIDTH-1:0] run_max;
  logic signed [SAMPLE_WIDTH-1:0] run_min;
  logic [GW-1:0]                  good_cnt;

  logic signed [SAMPLE_WIDTH-1:0] smp_c;
  logic                           crossing_c;
  logic                           arm_c;
  logic [PW1-1:0]                 period_full_c;
  logic [PERIOD_WIDTH-1:0]        period_sat_c;
  logic                           good_c;
  logic [GW-1:0]                  good_next_c;
  logic signed [SAMPLE_WIDTH-1:0] max_c;
  logic signed [SAMPLE_WIDTH-1:0] min_c;

  // Crossing takes priority over arming when evaluated on the same sample
  always_comb begin
    smp_c         = $signed(sample);
    crossing_c    = armed && !sample[SAMPLE_WIDTH-1];
    arm_c         = smp_c < ARM_LEVEL;
    period_full_c = PW1'(cnt) + PW1'(1);
    period_sat_c  = period_full_c[PERIOD_WIDTH] ? CNT_MAX : period_full_c[PERIOD_WIDTH-1:0];
    good_c        = (period_full_c >= PW1'(PER_LO)) && (period_full_c <= PW1'(PER_HI));
    good_next_c   = (good_cnt == GOOD_MAX) ? good_cnt : good_cnt + GW'(1);
    max_c         = (smp_c > run_max) ? smp_c : run_max;
    min_c         = (smp_c < run_min) ? smp_c : run_min;
  end

  always_ff @(posedge audioClock or negedge resetN) begin
    if (!resetN) begin
      armed     <= 1'b0;
      primed    <= 1'b0;
      cnt       <= '0;
      run_max   <= '0;
      run_min   <= '0;
      good_cnt  <= '0;
      measValid <= 1'b0;
      period    <= '0;
      peakPos   <= '0;
      peakNeg   <= '0;
      locked    <= 1'b0;
      timeout   <= 1'b0;
      errCount  <= '0;
    end else begin
      measValid <= 1'b0;
      if (sampleEnable) begin
        if (crossing_c) begin
          armed   <= 1'b0;
          primed  <= 1'b1;
          cnt     <= '0;
          run_max <= smp_c;
          run_min <= smp_c;
          // The first crossing after reset or timeout only primes the counter
          if (primed) begin
            measValid <= 1'b1;
            period    <= period_sat_c;
            peakPos   <= max_c;
            peakNeg   <= min_c;
            if (good_c) begin
              good_cnt <= good_next_c;
              locked   <= (good_next_c == GOOD_MAX);
            end else begin
              good_cnt <= '0;
              locked   <= 1'b0;
              if (errCount != 16'hFFFF) errCount <= errCount + 16'd1;
            end
          end
        end else begin
          if (arm_c) armed <= 1'b1;
          run_max <= max_c;
          run_min <= min_c;
          if (cnt == CNT_MAX) begin
            timeout  <= 1'b1;
            primed   <= 1'b0;
            locked   <= 1'b0;
            good_cnt <= '0;
          end else begin
            cnt <= cnt + PERIOD_WIDTH'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sine_tone_analyzer.sv
// Randomized bench for sine_tone_analyzer against a queue-based model of the
// current tone cycle (period = samples in cycle, peaks = extrema of the cycle).
module tb_sine_tone_analyzer;

  logic        audioClock = 1'b0;
  logic        resetN;
  logic        sampleEnable;
  logic [15:0] sample;
  logic        measValid;
  logic [7:0]  period;
  logic [15:0] peakPos;
  logic [15:0] peakNeg;
  logic        locked;
  logic        timeout;
  logic [15:0] errCount;

  int n_cmp = 0;
  int n_bad = 0;

  sine_tone_analyzer dut (
    .audioClock  (audioClock),
    .resetN      (resetN),
    .sampleEnable(sampleEnable),
    .sample      (sample),
    .measValid   (measValid),
    .period      (period),
    .peakPos     (peakPos),
    .peakNeg     (peakNeg),
    .locked      (locked),
    .timeout     (timeout),
    .errCount    (errCount)
  );

  always #5 audioClock = ~audioClock;

  logic [58:0] obs;
  assign obs = {measValid, period, peakPos, peakNeg, locked, timeout, errCount};

  // Model: samples of the current cycle, crossing flags, expected outputs
  int q[$];
  bit m_armed, m_primed;
  int m_run;
  bit e_mv, e_lk, e_to;
  int e_per, e_pp, e_pn, e_err;

  function automatic logic [58:0] exp_vec();
    return {e_mv, 8'(e_per), 16'(e_pp), 16'(e_pn), e_lk, e_to, 16'(e_err)};
  endfunction

  task automatic model_reset();
    q = {0};
    m_armed = 0; m_primed = 0; m_run = 0;
    e_mv = 0; e_lk = 0; e_to = 0;
    e_per = 0; e_pp = 0; e_pn = 0; e_err = 0;
  endtask

  task automatic model_strobe(input int s);
    int n, mx, mn;
    e_mv = 0;
    if (m_armed && s >= 0) begin
      m_armed = 0;
      if (m_primed) begin
        n = q.size(); mx = s; mn = s;
        foreach (q[k]) begin
          if (q[k] > mx) mx = q[k];
          if (q[k] < mn) mn = q[k];
        end
        e_mv = 1;
        e_per = (n > 255) ? 255 : n;
        e_pp = mx; e_pn = mn;
        if (n >= 47 && n <= 49) m_run++;
        else begin
          m_run = 0;
          if (e_err < 65535) e_err++;
        end
        e_lk = (m_run >= 4);
      end
      m_primed = 1;
      q = {s};
    end else begin
      if (q.size() >= 256) begin
        e_to = 1; m_primed = 0; m_run = 0; e_lk = 0;
      end
      q.push_back(s);
      if (s < -256) m_armed = 1;
    end
  endtask

  function automatic int sine_s(input int amp, input int per, input int i);
    return $rtoi(real'(amp) * $sin(2.0 * 3.14159265358979 * real'(i) / real'(per)));
  endfunction

  task automatic strobe(input int s);
    sampleEnable = 1'b1;
    sample = 16'(s);
    @(posedge audioClock); #1;
    sampleEnable = 1'b0;
    model_strobe(s);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge audioClock); #1;
      e_mv = 0;
    end
  endtask

  task automatic do_reset();
    resetN = 1'b0; sampleEnable = 1'b0; sample = '0;
    @(posedge audioClock); #1;
    model_reset();
    resetN = 1'b1;
  endtask

  task automatic test_reset();
    resetN = 1'b0; sampleEnable = 1'b0; sample = 16'h7FFF;
    @(posedge audioClock); #1;
    model_reset();
    n_cmp++;
    if (obs !== 59'd0) begin
      n_bad++; $display("FAIL reset_state: got %h want 0", obs);
    end
    resetN = 1'b1;
  endtask

  task automatic test_sine_lock();
    int ph, pulses;
    do_reset();
    ph = int'($urandom_range(47));
    pulses = 0;
    for (int i = 0; i < 7 * 48; i++) begin
      strobe(sine_s(30000, 48, i + ph));
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++; $display("FAIL sine_lock strobe %0d: got %h want %h", i, obs, exp_vec());
      end
      if (measValid === 1'b1) begin
        pulses++;
        n_cmp++;
        if (locked !== (pulses >= 4)) begin
          n_bad++; $display("FAIL lock_on_4th pulse %0d: got %b", pulses, locked);
        end
      end
    end
    n_cmp++;
    if (period !== 8'd48 || errCount !== 16'd0 || locked !== 1'b1 ||
        $signed(peakPos) < 29900 || $signed(peakNeg) > -29900) begin
      n_bad++;
      $display("FAIL sine_final: period %0d err %0d lock %b pp %0d pn %0d want 48 0 1 ~30000 ~-30000",
               period, errCount, locked, $signed(peakPos), $signed(peakNeg));
    end
  endtask

  task automatic test_slow_strobe();
    do_reset();
    for (int i = 0; i < 6 * 48; i++) begin
      strobe(sine_s(30000, 48, i));
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++; $display("FAIL slow strobe %0d: got %h want %h", i, obs, exp_vec());
      end
      idle(1);
      n_cmp++;
      if (obs !== exp_vec() || measValid !== 1'b0) begin
        n_bad++; $display("FAIL slow_pulse_width %0d: got %h want %h", i, obs, exp_vec());
      end
      idle(126);
    end
    n_cmp++;
    if (locked !== 1'b1 || period !== 8'd48) begin
      n_bad++; $display("FAIL slow_final: lock %b period %0d want 1 48", locked, period);
    end
  endtask

  task automatic test_wrong_period();
    for (int i = 0; i < 5 * 40; i++) begin
      strobe(sine_s(25000, 40, i));
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++; $display("FAIL wrong_period strobe %0d: got %h want %h", i, obs, exp_vec());
      end
    end
    n_cmp++;
    if (locked !== 1'b0 || errCount < 16'd3 || period !== 8'd40) begin
      n_bad++; $display("FAIL wrong_final: lock %b err %0d period %0d want 0 >=3 40",
                        locked, errCount, period);
    end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 300; i++) begin
      strobe(0);
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++; $display("FAIL timeout strobe %0d: got %h want %h", i, obs, exp_vec());
      end
    end
    n_cmp++;
    if (timeout !== 1'b1 || locked !== 1'b0) begin
      n_bad++; $display("FAIL timeout_flag: to %b lock %b want 1 0", timeout, locked);
    end
    for (int i = 0; i < 5 * 48; i++) begin
      strobe(sine_s(30000, 48, i));
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++; $display("FAIL reprime strobe %0d: got %h want %h", i, obs, exp_vec());
      end
    end
    n_cmp++;
    if (timeout !== 1'b1 || period !== 8'd48) begin
      n_bad++; $display("FAIL reprime_final: to %b period %0d want 1 48", timeout, period);
    end
  endtask

  task automatic test_noise();
    int s;
    do_reset();
    for (int i = 0; i < 500; i++) begin
      s = int'($urandom_range(200)) - 100;
      strobe(s);
      n_cmp++;
      if (obs !== exp_vec() || measValid !== 1'b0) begin
        n_bad++; $display("FAIL noise strobe %0d: got %h want %h", i, obs, exp_vec());
      end
    end
    n_cmp++;
    if (timeout !== 1'b1) begin
      n_bad++; $display("FAIL noise_timeout: got %b want 1", timeout);
    end
  endtask

  task automatic test_reset_mid();
    int amp;
    do_reset();
    amp = 20000 + int'($urandom_range(12000));
    for (int i = 0; i < 6 * 48; i++) strobe(sine_s(amp, 48, i));
    n_cmp++;
    if (locked !== 1'b1) begin
      n_bad++; $display("FAIL pre_reset_lock: got %b want 1", locked);
    end
    #3 resetN = 1'b0;
    #1;
    n_cmp++;
    if (obs !== 59'd0) begin
      n_bad++; $display("FAIL async_reset: got %h want 0", obs);
    end
    @(posedge audioClock); #1;
    resetN = 1'b1;
    model_reset();
    for (int i = 0; i < 6 * 48; i++) begin
      strobe(sine_s(amp, 48, i + 30));
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++; $display("FAIL relock strobe %0d: got %h want %h", i, obs, exp_vec());
      end
    end
    n_cmp++;
    if (locked !== 1'b1 || errCount !== 16'd0) begin
      n_bad++; $display("FAIL relock_final: lock %b err %0d want 1 0", locked, errCount);
    end
  endtask

  initial begin
    resetN = 1'b0; sampleEnable = 1'b0; sample = '0;
    model_reset();
    #2;
    test_reset();
    test_sine_lock();
    test_slow_strobe();
    test_wrong_period();
    test_timeout();
    test_noise();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
